// File: rtl/vesa_mode_pkg.sv
// vesa_mode_pkg: shared types and constants for the VESA mode controller.
//   vmc_mode_e   - 2-bit mode index (0=640x480, 1=1280x720, 2=1920x1080, 3=off)
//   vmc_timing_t - eight 16-bit timing fields plus H/V sync polarity (1=positive)
//   TIMING_*     - mode table constants; sync_e values are exclusive
package vesa_mode_pkg;

  typedef enum logic [1:0] {
    MODE_VGA   = 2'd0,
    MODE_720P  = 2'd1,
    MODE_1080P = 2'd2,
    MODE_OFF   = 2'd3
  } vmc_mode_e;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_total;
    logic [15:0] h_sync_s;
    logic [15:0] h_sync_e;
    logic [15:0] v_active;
    logic [15:0] v_total;
    logic [15:0] v_sync_s;
    logic [15:0] v_sync_e;
    logic        hs_pol;
    logic        vs_pol;
  } vmc_timing_t;

  localparam vmc_timing_t TIMING_VGA = '{
    h_active: 16'd640,  h_total: 16'd800,  h_sync_s: 16'd656,  h_sync_e: 16'd752,
    v_active: 16'd480,  v_total: 16'd525,  v_sync_s: 16'd490,  v_sync_e: 16'd492,
    hs_pol: 1'b0, vs_pol: 1'b0
  };

  localparam vmc_timing_t TIMING_720P = '{
    h_active: 16'd1280, h_total: 16'd1650, h_sync_s: 16'd1390, h_sync_e: 16'd1430,
    v_active: 16'd720,  v_total: 16'd750,  v_sync_s: 16'd725,  v_sync_e: 16'd730,
    hs_pol: 1'b1, vs_pol: 1'b1
  };

  localparam vmc_timing_t TIMING_1080P = '{
    h_active: 16'd1920, h_total: 16'd2200, h_sync_s: 16'd2008, h_sync_e: 16'd2052,
    v_active: 16'd1080, v_total: 16'd1125, v_sync_s: 16'd1084, v_sync_e: 16'd1089,
    hs_pol: 1'b1, vs_pol: 1'b1
  };

  localparam vmc_timing_t TIMING_OFF = '0;

endpackage

// File: rtl/vesa_mode_ctrl_if.sv
// vesa_mode_ctrl_if: mode-change request handshake.
//   req_valid - request valid (master -> slave)
//   req_mode  - requested mode index (master -> slave)
//   req_ready - request accepted when req_valid && req_ready (slave -> master)
interface vesa_mode_ctrl_if;
  logic       req_valid;
  logic [1:0] req_mode;
  logic       req_ready;

  modport master (output req_valid, output req_mode, input  req_ready);
  modport slave  (input  req_valid, input  req_mode, output req_ready);
endinterface

// File: rtl/vesa_mode_rom.sv
// vesa_mode_rom: combinational mode-index to timing-table lookup.
//   mode_i   - mode index
//   timing_o - timing values for that mode; all zeros for MODE_OFF
module vesa_mode_rom
  import vesa_mode_pkg::*;
(
  input  vmc_mode_e   mode_i,
  output vmc_timing_t timing_o
);

  always_comb begin
    timing_o = TIMING_OFF;
    case (mode_i)
      MODE_VGA:   timing_o = TIMING_VGA;
      MODE_720P:  timing_o = TIMING_720P;
      MODE_1080P: timing_o = TIMING_1080P;
      default:    timing_o = TIMING_OFF;
    endcase
  end

endmodule

// File: rtl/vesa_mode_ctrl.sv
// vesa_mode_ctrl: sequences video timing generator mode changes.
// A request is accepted in IDLE or RUN; a running generator is drained to
// the end of its current frame before new timing is loaded, then the block
// waits FRAME_WAIT complete frames before reporting video_ok.
//   clk, rst_n            - pixel clock; reset is asynchronous, active-high
//   req (slave)           - req_valid / req_mode / req_ready handshake
//   gen_h_count/v_count   - counters from the timing generator
//   gen_en, gen_load      - generator enable and one-cycle load strobe
//   gen_* timing, *_pol   - current timing values and sync polarities
//   cur_mode, video_ok    - active mode and timing-stable flag
//   err                   - sticky watchdog error
// Optional feature: define VMC_WATCHDOG_EN to build a DRAIN/START watchdog
// that aborts to IDLE after TIMEOUT_CYCLES without a frame end.
module vesa_mode_ctrl
  import vesa_mode_pkg::*;
#(
  parameter int unsigned FRAME_WAIT     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
  input  logic               clk,
  input  logic               rst_n,
  vesa_mode_ctrl_if.slave    req,
  input  logic [15:0]        gen_h_count,
  input  logic [15:0]        gen_v_count,
  output logic               gen_en,
  output logic               gen_load,
  output logic [15:0]        gen_h_active,
  output logic [15:0]        gen_h_total,
  output logic [15:0]        gen_h_sync_s,
  output logic [15:0]        gen_h_sync_e,
  output logic [15:0]        gen_v_active,
  output logic [15:0]        gen_v_total,
  output logic [15:0]        gen_v_sync_s,
  output logic [15:0]        gen_v_sync_e,
  output logic               gen_hs_pol,
  output logic               gen_vs_pol,
  output logic [1:0]         cur_mode,
  output logic               video_ok,
  output logic               err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_LOAD,
    ST_START,
    ST_RUN
  } state_e;

  state_e      state_q, state_d;
  vmc_mode_e   cur_mode_q, cur_mode_d;
  vmc_mode_e   pend_q, pend_d;
  vmc_mode_e   rom_sel;
  vmc_timing_t timing_q, timing_d;
  vmc_timing_t rom_timing;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        frame_end;
  logic        wd_expired;
  logic        ready_w;

  // State decodes; none of these look at req_valid.
  assign gen_en        = (state_q == ST_DRAIN) || (state_q == ST_START) || (state_q == ST_RUN);
  assign gen_load      = (state_q == ST_LOAD);
  assign video_ok      = (state_q == ST_RUN);
  assign ready_w       = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign req.req_ready = ready_w;

  assign frame_end = gen_en
                  && (gen_h_count == timing_q.h_total - 16'd1)
                  && (gen_v_count == timing_q.v_total - 16'd1);

  // Timing is registered on the edge entering LOAD, so the new values are
  // already on the outputs during the gen_load cycle.
  assign rom_sel = (state_q == ST_IDLE) ? vmc_mode_e'(req.req_mode) : pend_q;

  vesa_mode_rom u_rom (
    .mode_i   (rom_sel),
    .timing_o (rom_timing)
  );

  always_comb begin
    state_d     = state_q;
    cur_mode_d  = cur_mode_q;
    pend_d      = pend_q;
    timing_d    = timing_q;
    frame_cnt_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (req.req_valid && (req.req_mode != MODE_OFF)) begin
          state_d    = ST_LOAD;
          cur_mode_d = vmc_mode_e'(req.req_mode);
          pend_d     = vmc_mode_e'(req.req_mode);
          timing_d   = rom_timing;
        end
      end
      ST_LOAD: begin
        state_d = ST_START;
      end
      ST_START: begin
        frame_cnt_d = frame_cnt_q;
        if (frame_end) begin
          if ((32'(frame_cnt_q) + 32'd1) >= FRAME_WAIT) begin
            state_d = ST_RUN;
          end
          if (frame_cnt_q != '1) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end
      end
      ST_RUN: begin
        if (req.req_valid && (req.req_mode != cur_mode_q)) begin
          pend_d  = vmc_mode_e'(req.req_mode);
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (frame_end) begin
          if (pend_q == MODE_OFF) begin
            state_d    = ST_IDLE;
            cur_mode_d = MODE_OFF;
            timing_d   = TIMING_OFF;
          end else begin
            state_d    = ST_LOAD;
            cur_mode_d = pend_q;
            timing_d   = rom_timing;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (wd_expired) begin
      state_d    = ST_IDLE;
      cur_mode_d = MODE_OFF;
      timing_d   = TIMING_OFF;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= ST_IDLE;
      cur_mode_q  <= MODE_OFF;
      pend_q      <= MODE_OFF;
      timing_q    <= TIMING_OFF;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_mode_q  <= cur_mode_d;
      pend_q      <= pend_d;
      timing_q    <= timing_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef VMC_WATCHDOG_EN
  logic [31:0] wd_cnt_q, wd_cnt_d;
  logic        err_q, err_d;

  assign wd_expired = ((state_q == ST_DRAIN) || (state_q == ST_START))
                   && !frame_end
                   && (wd_cnt_q == TIMEOUT_CYCLES - 32'd1);

  // Held at zero outside DRAIN/START, which also gives the clear on entry.
  always_comb begin
    wd_cnt_d = '0;
    if (((state_q == ST_DRAIN) || (state_q == ST_START)) && !frame_end && !wd_expired) begin
      wd_cnt_d = wd_cnt_q + 32'd1;
    end
  end

  always_comb begin
    err_d = err_q;
    if (wd_expired) begin
      err_d = 1'b1;
    end else if (req.req_valid && ready_w) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err = err_q;
`else
  // TIMEOUT_CYCLES only matters when the watchdog is built in.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign wd_expired     = 1'b0;
  assign err            = 1'b0;
`endif

  assign cur_mode     = cur_mode_q;
  assign gen_h_active = timing_q.h_active;
  assign gen_h_total  = timing_q.h_total;
  assign gen_h_sync_s = timing_q.h_sync_s;
  assign gen_h_sync_e = timing_q.h_sync_e;
  assign gen_v_active = timing_q.v_active;
  assign gen_v_total  = timing_q.v_total;
  assign gen_v_sync_s = timing_q.v_sync_s;
  assign gen_v_sync_e = timing_q.v_sync_e;
  assign gen_hs_pol   = timing_q.hs_pol;
  assign gen_vs_pol   = timing_q.vs_pol;

endmodule

// File: tb/tb_vesa_mode_ctrl.sv
// tb_vesa_mode_ctrl: self-checking bench for vesa_mode_ctrl. The bench plays
// the timing generator, jumping the counters straight to frame-end values.
// Expected load contents are queued when a request is issued and checked when
// gen_load appears.
module tb_vesa_mode_ctrl;

  typedef struct {
    logic [63:0] h;
    logic [63:0] v;
    logic [3:0]  pm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] gen_h_count, gen_v_count;
  logic        gen_en, gen_load;
  logic [15:0] gen_h_active, gen_h_total, gen_h_sync_s, gen_h_sync_e;
  logic [15:0] gen_v_active, gen_v_total, gen_v_sync_s, gen_v_sync_e;
  logic        gen_hs_pol, gen_vs_pol;
  logic [1:0]  cur_mode;
  logic        video_ok, err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  exp_t        exp_q[$];
  exp_t        e_mon;

  vesa_mode_ctrl_if req_if ();

  vesa_mode_ctrl #(
    .FRAME_WAIT     (2),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req_if),
    .gen_h_count  (gen_h_count),
    .gen_v_count  (gen_v_count),
    .gen_en       (gen_en),
    .gen_load     (gen_load),
    .gen_h_active (gen_h_active),
    .gen_h_total  (gen_h_total),
    .gen_h_sync_s (gen_h_sync_s),
    .gen_h_sync_e (gen_h_sync_e),
    .gen_v_active (gen_v_active),
    .gen_v_total  (gen_v_total),
    .gen_v_sync_s (gen_v_sync_s),
    .gen_v_sync_e (gen_v_sync_e),
    .gen_hs_pol   (gen_hs_pol),
    .gen_vs_pol   (gen_vs_pol),
    .cur_mode     (cur_mode),
    .video_ok     (video_ok),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, expv, expv);
    end
  endtask

  function automatic exp_t mode_exp(input int m);
    exp_t e;
    case (m)
      0: begin
        e.h  = {16'd640, 16'd800, 16'd656, 16'd752};
        e.v  = {16'd480, 16'd525, 16'd490, 16'd492};
        e.pm = {1'b0, 1'b0, 2'd0};
      end
      1: begin
        e.h  = {16'd1280, 16'd1650, 16'd1390, 16'd1430};
        e.v  = {16'd720, 16'd750, 16'd725, 16'd730};
        e.pm = {1'b1, 1'b1, 2'd1};
      end
      2: begin
        e.h  = {16'd1920, 16'd2200, 16'd2008, 16'd2052};
        e.v  = {16'd1080, 16'd1125, 16'd1084, 16'd1089};
        e.pm = {1'b1, 1'b1, 2'd2};
      end
      default: begin
        e.h  = '0;
        e.v  = '0;
        e.pm = {1'b0, 1'b0, 2'd3};
      end
    endcase
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_counts(input int h, input int v);
    gen_h_count = 16'(h);
    gen_v_count = 16'(v);
  endtask

  task automatic frame_pulse(input int ht, input int vt);
    set_counts(ht - 1, vt - 1);
    tick(1);
    set_counts(0, 0);
  endtask

  // Returns just after the accepting edge.
  task automatic send_req(input logic [1:0] m);
    int unsigned n = 0;
    req_if.req_valid = 1'b1;
    req_if.req_mode  = m;
    while (!req_if.req_ready && n < 50) begin
      tick(1);
      n++;
    end
    chk("req_ready_wait", 64'(req_if.req_ready), 64'd1);
    tick(1);
    req_if.req_valid = 1'b0;
  endtask

  // Scoreboard: every gen_load must match the oldest queued expectation.
  always @(negedge clk) begin
    if (gen_load) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_load", 64'(gen_load), 64'd0);
      end else begin
        e_mon = exp_q.pop_front();
        chk("load_h", {gen_h_active, gen_h_total, gen_h_sync_s, gen_h_sync_e}, e_mon.h);
        chk("load_v", {gen_v_active, gen_v_total, gen_v_sync_s, gen_v_sync_e}, e_mon.v);
        chk("load_pol_mode", 64'({gen_hs_pol, gen_vs_pol, cur_mode}), 64'(e_mon.pm));
        chk("load_gen_en", 64'(gen_en), 64'd0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "bench timed out");
  end

  initial begin
    int unsigned n;
    rst_n            = 1'b1;
    req_if.req_valid = 1'b0;
    req_if.req_mode  = 2'd0;
    set_counts(0, 0);
    tick(3);
    chk("rst_gen_en", 64'(gen_en), 64'd0);
    chk("rst_gen_load", 64'(gen_load), 64'd0);
    chk("rst_cur_mode", 64'(cur_mode), 64'd3);
    chk("rst_video_ok", 64'(video_ok), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_timing", {gen_h_total, gen_v_total, gen_h_active, gen_v_sync_e}, 64'd0);
    chk("rst_pol", 64'({gen_hs_pol, gen_vs_pol}), 64'd0);
    chk("rst_ready", 64'(req_if.req_ready), 64'd1);
    rst_n = 1'b0;
    tick(1);

    // Bring up 1080p.
    exp_q.push_back(mode_exp(2));
    send_req(2'd2);
    chk("load_pulse_m2", 64'(gen_load), 64'd1);
    tick(1);
    chk("start_en", 64'(gen_en), 64'd1);
    chk("start_ready", 64'(req_if.req_ready), 64'd0);
    chk("start_vok", 64'(video_ok), 64'd0);
    chk("start_load_gone", 64'(gen_load), 64'd0);
    set_counts(2199, 1123);
    tick(1);
    set_counts(2198, 1124);
    tick(1);
    set_counts(0, 0);
    chk("near_miss_vok", 64'(video_ok), 64'd0);
    frame_pulse(2200, 1125);
    chk("vok_after_1_frame", 64'(video_ok), 64'd0);
    frame_pulse(2200, 1125);
    chk("vok_after_2_frames", 64'(video_ok), 64'd1);
    chk("run_ready", 64'(req_if.req_ready), 64'd1);
    chk("run_mode2", 64'(cur_mode), 64'd2);

    // 1080p -> VGA requested mid-frame; must drain to frame end.
    set_counts(100, 500);
    exp_q.push_back(mode_exp(0));
    send_req(2'd0);
    chk("drain_vok", 64'(video_ok), 64'd0);
    chk("drain_en", 64'(gen_en), 64'd1);
    chk("drain_mode_kept", 64'(cur_mode), 64'd2);
    req_if.req_valid = 1'b1;
    req_if.req_mode  = 2'd1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_ready", 64'(req_if.req_ready), 64'd0);
      tick(1);
    end
    set_counts(2199, 500);
    tick(1);
    chk("drain_en_hold", 64'(gen_en), 64'd1);
    req_if.req_valid = 1'b0;
    set_counts(2199, 1124);
    tick(1);
    set_counts(0, 0);
    chk("drain_to_load", 64'(gen_load), 64'd1);
    chk("load_en_low", 64'(gen_en), 64'd0);
    tick(1);
    frame_pulse(800, 525);
    frame_pulse(800, 525);
    chk("run_mode0", 64'(cur_mode), 64'd0);
    chk("run_vok0", 64'(video_ok), 64'd1);

    // VGA -> 720p.
    exp_q.push_back(mode_exp(1));
    send_req(2'd1);
    frame_pulse(800, 525);
    tick(1);
    frame_pulse(1650, 750);
    frame_pulse(1650, 750);
    chk("run_mode1", 64'(cur_mode), 64'd1);

    // Same-mode request: accepted immediately, no reload.
    req_if.req_valid = 1'b1;
    req_if.req_mode  = 2'd1;
    chk("same_ready", 64'(req_if.req_ready), 64'd1);
    tick(1);
    req_if.req_valid = 1'b0;
    chk("same_vok", 64'(video_ok), 64'd1);
    chk("same_en", 64'(gen_en), 64'd1);
    tick(2);
    chk("same_no_load", 64'(gen_load), 64'd0);
    chk("same_mode", 64'(cur_mode), 64'd1);

    // Disable.
    send_req(2'd3);
    chk("off_drain_en", 64'(gen_en), 64'd1);
    frame_pulse(1650, 750);
    chk("off_en", 64'(gen_en), 64'd0);
    chk("off_mode", 64'(cur_mode), 64'd3);
    chk("off_vok", 64'(video_ok), 64'd0);
    chk("off_ready", 64'(req_if.req_ready), 64'd1);
    chk("off_timing", 64'(gen_h_total), 64'd0);
    send_req(2'd3);
    tick(2);
    chk("idle_off_stays", 64'(gen_en), 64'd0);

    // Asynchronous reset in the middle of START.
    exp_q.push_back(mode_exp(0));
    send_req(2'd0);
    tick(1);
    frame_pulse(800, 525);
    #2 rst_n = 1'b1;
    #1;
    chk("async_rst_en", 64'(gen_en), 64'd0);
    chk("async_rst_mode", 64'(cur_mode), 64'd3);
    chk("async_rst_timing", 64'(gen_h_total), 64'd0);
    tick(1);
    rst_n = 1'b0;
    tick(1);
    frame_pulse(800, 525);
    chk("rst_start_abandoned", 64'(gen_en), 64'd0);
    chk("rst_start_vok", 64'(video_ok), 64'd0);

    // Reset in the middle of DRAIN drops the pending mode.
    exp_q.push_back(mode_exp(0));
    send_req(2'd0);
    tick(1);
    frame_pulse(800, 525);
    frame_pulse(800, 525);
    chk("pre_drain_run", 64'(video_ok), 64'd1);
    send_req(2'd2);
    rst_n = 1'b1;
    tick(1);
    rst_n = 1'b0;
    tick(1);
    frame_pulse(800, 525);
    tick(2);
    chk("rst_drain_en", 64'(gen_en), 64'd0);
    chk("rst_drain_mode", 64'(cur_mode), 64'd3);

    // Counters frozen in START.
    exp_q.push_back(mode_exp(0));
    send_req(2'd0);
    tick(1);
    n = 0;
`ifdef VMC_WATCHDOG_EN
    while (!err && n < 1100) begin
      tick(1);
      n++;
    end
    chk("wd_cycles", 64'(n), 64'd1000);
    chk("wd_err", 64'(err), 64'd1);
    chk("wd_en", 64'(gen_en), 64'd0);
    chk("wd_mode", 64'(cur_mode), 64'd3);
    chk("wd_ready", 64'(req_if.req_ready), 64'd1);
    exp_q.push_back(mode_exp(1));
    send_req(2'd1);
    chk("wd_err_clear", 64'(err), 64'd0);
    tick(1);
`else
    while (n < 1100) begin
      tick(1);
      n++;
    end
    chk("no_wd_err", 64'(err), 64'd0);
    chk("no_wd_en", 64'(gen_en), 64'd1);
`endif

    tick(2);
    chk("all_loads_seen", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
